// File: rtl/rs232_pkg.sv
`default_nettype none
// ============================================================================
// Package     : rs232_pkg
// Description : Shared RS232 definitions: parity codes, FSM state encoding,
//               baud divisor helper. Used by rs232_tx and the future rs232_rx.
// Revision    : 1.0 - initial release
// ============================================================================
package rs232_pkg;

    localparam int c_parity_none = 0;
    localparam int c_parity_odd  = 1;
    localparam int c_parity_even = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5
    } rs232_state_t;

    // Rounded clock cycles per bit.
    function automatic int baud_div(input int clk_freq, input int baud_rate);
        return (clk_freq + baud_rate / 2) / baud_rate;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rs232_tx_if.sv
`default_nettype none
// ============================================================================
// Interface   : rs232_tx_if
// Description : FIFO read port between a TX FIFO (master) and rs232_tx (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface rs232_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_pop;

    modport master (
        output fifo_empty,
        output fifo_data,
        input  fifo_pop
    );

    modport slave (
        input  fifo_empty,
        input  fifo_data,
        output fifo_pop
    );
endinterface
`default_nettype wire

// File: rtl/rs232_baud_gen.sv
`default_nettype none
// ============================================================================
// Module      : rs232_baud_gen
// Description : Bit-period counter; bit_tick marks the last clk of each bit,
//               pre_tick the clk before it. Restart realigns to a bit start.
// Revision    : 1.0 - initial release
// ============================================================================
module rs232_baud_gen #(
    parameter int DIV = 16
) (
    input  wire logic clk,
    input  wire logic clear_n,
    input  wire logic i_restart,
    output logic      o_bit_tick,
    output logic      o_pre_tick
);
    localparam int              c_cw   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_cw-1:0] c_last = c_cw'(DIV - 1);
    localparam logic [c_cw-1:0] c_pre  = c_cw'(DIV - 2);

    logic [c_cw-1:0] r_cnt;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_cnt <= '0;
        end else if (i_restart || (r_cnt == c_last)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_bit_tick = (r_cnt == c_last);
    assign o_pre_tick = (r_cnt == c_pre);
endmodule
`default_nettype wire

// File: rtl/rs232_tx.sv
`default_nettype none
// ============================================================================
// Module      : rs232_tx
// Description : RS232 transmitter; pops words from the TX FIFO and sends them
//               as start / LSB-first data / optional parity / stop frames.
// Revision    : 1.0 - initial release
// ============================================================================
module rs232_tx
    import rs232_pkg::*;
#(
    parameter int CLK_FREQ     = 50000000,
    parameter int BAUD_RATE    = 115200,
    parameter int DATA_WIDTH   = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int READ_LATENCY = 1
) (
    input  wire logic clk,
    input  wire logic clear_n,
    input  wire logic enable,
    rs232_tx_if.slave fifo,
    output logic      tx,
    output logic      busy,
    output logic      byte_done
);
    localparam int              c_div       = baud_div(CLK_FREQ, BAUD_RATE);
    localparam int              c_bw        = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [c_bw-1:0] c_last_bit  = c_bw'(DATA_WIDTH - 1);
    localparam logic            c_last_stop = 1'(STOP_BITS - 1);
    localparam logic [1:0]      c_lat       = 2'(READ_LATENCY);
    localparam bit              c_has_par   = (PARITY != c_parity_none);

    rs232_state_t          r_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_par;
    logic [c_bw-1:0]       r_bit;
    logic                  r_stop;
    logic [1:0]            r_lat;

    logic w_tick;
    logic w_pre;
    logic w_latch;
    logic w_par;
    logic w_start_next;

    assign w_latch      = (r_state == ST_FETCH) && (r_lat == c_lat);
    assign w_par        = (PARITY == c_parity_odd) ? ~^fifo.fifo_data : ^fifo.fifo_data;
    assign w_start_next = enable && !fifo.fifo_empty;

    // Realigning on the latch clk makes the start bit begin at count zero.
    rs232_baud_gen #(
        .DIV (c_div)
    ) u_baud (
        .clk        (clk),
        .clear_n    (clear_n),
        .i_restart  (w_latch),
        .o_bit_tick (w_tick),
        .o_pre_tick (w_pre)
    );

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_state       <= ST_IDLE;
            tx            <= 1'b1;
            fifo.fifo_pop <= 1'b0;
            busy          <= 1'b0;
            byte_done     <= 1'b0;
            r_shift       <= '0;
            r_par         <= 1'b0;
            r_bit         <= '0;
            r_stop        <= 1'b0;
            r_lat         <= '0;
        end else begin
            fifo.fifo_pop <= 1'b0;
            byte_done     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    tx   <= 1'b1;
                    busy <= 1'b0;
                    if (w_start_next) begin
                        fifo.fifo_pop <= 1'b1;
                        busy          <= 1'b1;
                        r_lat         <= '0;
                        r_state       <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (w_latch) begin
                        r_shift <= fifo.fifo_data;
                        r_par   <= w_par;
                        tx      <= 1'b0;
                        r_state <= ST_START;
                    end else begin
                        r_lat <= r_lat + 1'b1;
                    end
                end
                ST_START: begin
                    if (w_tick) begin
                        tx      <= r_shift[0];
                        r_shift <= r_shift >> 1;
                        r_bit   <= '0;
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        if (r_bit == c_last_bit) begin
                            r_stop <= 1'b0;
                            if (c_has_par) begin
                                tx      <= r_par;
                                r_state <= ST_PARITY;
                            end else begin
                                tx      <= 1'b1;
                                r_state <= ST_STOP;
                            end
                        end else begin
                            tx      <= r_shift[0];
                            r_shift <= r_shift >> 1;
                            r_bit   <= r_bit + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_tick) begin
                        tx      <= 1'b1;
                        r_state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    // Registered pulse: armed one clk early so it lands on the final clk.
                    if (w_pre && (r_stop == c_last_stop)) begin
                        byte_done <= 1'b1;
                    end
                    if (w_tick) begin
                        if (r_stop == c_last_stop) begin
                            if (w_start_next) begin
                                fifo.fifo_pop <= 1'b1;
                                r_lat         <= '0;
                                r_state       <= ST_FETCH;
                            end else begin
                                busy    <= 1'b0;
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_stop <= r_stop + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_rs232_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_rs232_tx
// Description : Self-checking bench for rs232_tx; three instances (no parity,
//               even/2 stop, odd/2 stop), each fed by a 3-deep FIFO model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rs232_tx;
    localparam int c_div = 16;
    localparam int c_lat = 1;

    logic       clk = 1'b0;
    logic       clear_n;
    logic [2:0] enable;
    logic [2:0] push_req;
    logic [7:0] push_data;
    logic       fifo_init;

    wire [2:0] tx_w;
    wire [2:0] busy_w;
    wire [2:0] done_w;
    wire [2:0] pop_w;
    wire [2:0] empty_w;
    wire [2:0] pop_err_w;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic int par_of(input int ch);
        return (ch == 0) ? 0 : ((ch == 1) ? 2 : 1);
    endfunction

    function automatic int stop_of(input int ch);
        return (ch == 0) ? 1 : 2;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_ch
        rs232_tx_if #(.DATA_WIDTH(8)) fif ();
        logic [7:0] q[$];
        int         pops;
        logic       uflow;
        logic       dbl;
        logic       prev_pop;

        rs232_tx #(
            .CLK_FREQ     (16),
            .BAUD_RATE    (1),
            .DATA_WIDTH   (8),
            .PARITY       ((g == 0) ? 0 : ((g == 1) ? 2 : 1)),
            .STOP_BITS    ((g == 0) ? 1 : 2),
            .READ_LATENCY (c_lat)
        ) dut (
            .clk       (clk),
            .clear_n   (clear_n),
            .enable    (enable[g]),
            .fifo      (fif),
            .tx        (tx_w[g]),
            .busy      (busy_w[g]),
            .byte_done (done_w[g])
        );

        assign pop_w[g]     = fif.fifo_pop;
        assign empty_w[g]   = fif.fifo_empty;
        assign pop_err_w[g] = uflow | dbl;

        // FIFO with one clk read latency; it is not cleared by the DUT reset.
        always @(posedge clk) begin
            if (fifo_init) begin
                q.delete();
                fif.fifo_empty <= 1'b1;
                fif.fifo_data  <= 8'h00;
                pops           <= 0;
                uflow          <= 1'b0;
                dbl            <= 1'b0;
                prev_pop       <= 1'b0;
            end else begin
                prev_pop <= fif.fifo_pop;
                if (fif.fifo_pop) begin
                    pops <= pops + 1;
                    if (prev_pop) dbl <= 1'b1;
                    if (q.size() == 0) uflow <= 1'b1;
                    else fif.fifo_data <= q.pop_front();
                end
                if (push_req[g] && q.size() < 3) q.push_back(push_data);
                fif.fifo_empty <= (q.size() == 0);
            end
        end
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic push_one(input int ch, input logic [7:0] d);
        push_req[ch] = 1'b1;
        push_data    = d;
        @(negedge clk);
        push_req[ch] = 1'b0;
    endtask

    // Reference frame built from the framing rules, compared clk by clk.
    task automatic check_frame(input int ch, input logic [7:0] w, input int en_off_at,
                               output int gap, output logic par_seen, output int done_at);
        logic [11:0] bits;
        int          n;
        int          idx;
        int          done_cnt;
        logic        bad_bit;
        logic        busy_ok;
        n    = 0;
        bits = '0;
        bits[n] = 1'b0; n++;
        for (int i = 0; i < 8; i++) begin bits[n] = w[i]; n++; end
        if (par_of(ch) != 0) begin
            bits[n] = (par_of(ch) == 2) ? ^w : ~^w;
            n++;
        end
        for (int i = 0; i < stop_of(ch); i++) begin bits[n] = 1'b1; n++; end
        gap = 0; par_seen = 1'b0; done_at = 0; done_cnt = 0; busy_ok = 1'b1;
        @(negedge clk);
        while (tx_w[ch] !== 1'b0 && gap < 400) begin
            gap++;
            @(negedge clk);
        end
        checks++;
        if (tx_w[ch] !== 1'b0) begin
            failures++;
            $display("FAIL start_wait ch%0d word %h: tx=%b after %0d clk, required 0", ch, w, tx_w[ch], gap);
            return;
        end
        for (int b = 0; b < n; b++) begin
            bad_bit = 1'b0;
            for (int c = 0; c < c_div; c++) begin
                idx = b * c_div + c + 1;
                if (b != 0 || c != 0) @(negedge clk);
                if (idx == en_off_at) enable[ch] = 1'b0;
                if (tx_w[ch] !== bits[b]) bad_bit = 1'b1;
                if (done_w[ch] === 1'b1) begin done_cnt++; done_at = idx; end
                if (busy_w[ch] !== 1'b1) busy_ok = 1'b0;
                if (b == 9 && c == c_div / 2) par_seen = tx_w[ch];
            end
            checks++;
            if (bad_bit) begin
                failures++;
                $display("FAIL frame_bit ch%0d word %h bit %0d: line differed, required %b for %0d clk",
                         ch, w, b, bits[b], c_div);
            end
        end
        check("byte_done_count", done_cnt, 1);
        check("busy_in_frame", int'(busy_ok), 1);
    endtask

    typedef struct {
        int         ch;
        logic [7:0] data;
        logic       exp_par;
        int         exp_len;
    } vec_t;

    vec_t vt[7];

    initial begin
        int   gap;
        int   done_at;
        int   p0;
        int   k;
        logic par_seen;
        logic ok;
        logic [7:0] words[3];

        vt[0] = '{0, 8'hAC, 1'b0, 160};
        vt[1] = '{1, 8'h7D, 1'b0, 192};
        vt[2] = '{2, 8'h7D, 1'b1, 192};
        vt[3] = '{1, 8'h61, 1'b1, 192};
        vt[4] = '{2, 8'h61, 1'b0, 192};
        vt[5] = '{2, 8'hFF, 1'b1, 192};
        vt[6] = '{1, 8'h00, 1'b0, 192};

        clear_n   = 1'b0;
        enable    = 3'b000;
        push_req  = 3'b000;
        push_data = 8'h00;
        fifo_init = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_tx", int'(tx_w), 7);
        check("reset_busy", int'(busy_w), 0);
        check("reset_pop", int'(pop_w), 0);
        check("reset_byte_done", int'(done_w), 0);

        fifo_init = 1'b0;
        enable    = 3'b111;
        clear_n   = 1'b1;
        ok = 1'b1;
        repeat (500) begin
            @(negedge clk);
            if (tx_w !== 3'b111 || pop_w !== 3'b000 || busy_w !== 3'b000) ok = 1'b0;
        end
        check("idle_empty_500clk", int'(ok), 1);

        // Pop one clk after the FIFO first reports non-empty.
        p0 = g_ch[0].pops;
        push_one(0, 8'hAC);
        check("refill_empty_seen", int'(empty_w[0]), 0);
        check("refill_no_early_pop", int'(pop_w[0]), 0);
        @(negedge clk);
        check("refill_pop_next_clk", int'(pop_w[0]), 1);
        check_frame(0, 8'hAC, 0, gap, par_seen, done_at);
        check("ac_done_at", done_at, 160);
        check("ac_single_pop", g_ch[0].pops - p0, 1);

        for (int i = 0; i < 7; i++) begin
            push_one(vt[i].ch, vt[i].data);
            check_frame(vt[i].ch, vt[i].data, 0, gap, par_seen, done_at);
            check("table_frame_len", done_at, vt[i].exp_len);
            if (par_of(vt[i].ch) != 0) check("table_parity_bit", int'(par_seen), int'(vt[i].exp_par));
        end

        // Three queued words go out without returning to idle.
        p0 = g_ch[0].pops;
        push_one(0, 8'h61);
        push_one(0, 8'h11);
        push_one(0, 8'h39);
        check_frame(0, 8'h61, 0, gap, par_seen, done_at);
        check_frame(0, 8'h11, 0, gap, par_seen, done_at);
        check("b2b_gap2", gap, c_lat + 1);
        check_frame(0, 8'h39, 0, gap, par_seen, done_at);
        check("b2b_gap3", gap, c_lat + 1);
        @(negedge clk);
        check("b2b_busy_fall", int'(busy_w[0]), 0);
        check("b2b_fifo_empty", int'(empty_w[0]), 1);
        check("b2b_pops", g_ch[0].pops - p0, 3);

        // enable dropped mid-frame.
        p0 = g_ch[0].pops;
        push_one(0, 8'h3C);
        push_one(0, 8'hC3);
        check_frame(0, 8'h3C, 40, gap, par_seen, done_at);
        check("en_off_frame_len", done_at, 160);
        ok = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || pop_w[0] !== 1'b0) ok = 1'b0;
        end
        check("en_off_stays_idle", int'(ok), 1);
        check("en_off_pops", g_ch[0].pops - p0, 1);
        enable[0] = 1'b1;
        check_frame(0, 8'hC3, 0, gap, par_seen, done_at);
        check("en_on_pops", g_ch[0].pops - p0, 2);

        // Asynchronous clear in the middle of a data bit that is low.
        p0 = g_ch[0].pops;
        push_one(0, 8'h00);
        push_one(0, 8'hA5);
        k = 0;
        while (tx_w[0] !== 1'b0 && k < 400) begin
            k++;
            @(negedge clk);
        end
        check("clr_frame_started", int'(tx_w[0]), 0);
        repeat (49) @(negedge clk);
        check("clr_line_low_before", int'(tx_w[0]), 0);
        #1 clear_n = 1'b0;
        #1;
        check("clr_tx_async", int'(tx_w[0]), 1);
        check("clr_busy_async", int'(busy_w[0]), 0);
        @(negedge clk);
        @(negedge clk);
        clear_n = 1'b1;
        check_frame(0, 8'hA5, 0, gap, par_seen, done_at);
        check("clr_next_frame_len", done_at, 160);
        check("clr_pops", g_ch[0].pops - p0, 2);

        // Random bursts on random channels against the reference frames.
        for (int r = 0; r < 6; r++) begin
            int ch;
            int n;
            ch = int'($urandom_range(2, 0));
            n  = int'($urandom_range(3, 1));
            for (int i = 0; i < n; i++) words[i] = 8'($urandom);
            for (int i = 0; i < n; i++) push_one(ch, words[i]);
            for (int i = 0; i < n; i++) begin
                check_frame(ch, words[i], 0, gap, par_seen, done_at);
                check("rand_frame_len", done_at, (10 + ((par_of(ch) != 0) ? 1 : 0) + stop_of(ch) - 1) * c_div);
                if (i > 0) check("rand_gap", gap, c_lat + 1);
            end
        end

        repeat (4) @(negedge clk);
        check("no_bad_pop", int'(pop_err_w), 0);
        check("all_fifos_empty", int'(empty_w), 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
